// File: rtl/game_pkg.sv
// rtl/game_pkg.sv - shared state encodings and screen constants for the dino game
package game_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_START = 2'd0;
  localparam state_t ST_PLAY  = 2'd1;
  localparam state_t ST_OVER  = 2'd2;
  localparam state_t ST_DYING = 2'd3;

  localparam int H_ACTIVE = 640;
  localparam int V_ACTIVE = 480;

  // DYING and OVER both freeze the world and show the death sprite
  function automatic logic is_dead(input state_t s);
    return (s == ST_DYING) || (s == ST_OVER);
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// rtl/btn_debounce.sv - per-bit synchroniser, OR-combine, debounce and rising-edge press pulse
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int WIDTH           = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] btn_raw,
  output logic             press
);

  localparam int CW = ($clog2(DEBOUNCE_CYCLES + 1) < 1) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);

  logic [WIDTH-1:0] sync1;
  logic [WIDTH-1:0] sync2;
  logic             btn_any;
  logic             level;
  logic [CW-1:0]    cnt;

  assign btn_any = |sync2;

  // cnt counts consecutive samples that disagree with the accepted level
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1 <= '0;
      sync2 <= '0;
      level <= 1'b0;
      cnt   <= '0;
      press <= 1'b0;
    end else begin
      sync1 <= btn_raw;
      sync2 <= sync1;
      press <= 1'b0;
      if (btn_any == level) begin
        cnt <= '0;
      end else if (32'(cnt) + 1 >= DEBOUNCE_CYCLES) begin
        cnt   <= '0;
        level <= btn_any;
        press <= btn_any;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/game_flow_ctrl.sv
// rtl/game_flow_ctrl.sv - game state machine, collision latch, halt and round-reset generation
module game_flow_ctrl
  import game_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int GRACE_FRAMES    = 30,
  parameter int DEATH_FRAMES    = 60,
  parameter int SCORE_W         = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [3:0]         btn_raw,
  input  logic               debug,
  input  logic               frame_tick,
  input  logic               active_video,
  input  logic               hit,
  output logic [1:0]         game_state,
  output logic               halt,
  output logic               show_death,
  output logic               round_reset,
  output logic [SCORE_W-1:0] play_frames
);

  localparam int GW = ($clog2(GRACE_FRAMES + 1) < 1) ? 1 : $clog2(GRACE_FRAMES + 1);
  localparam int DW = ($clog2(DEATH_FRAMES + 1) < 1) ? 1 : $clog2(DEATH_FRAMES + 1);

  state_t        state;
  logic [GW-1:0] grace_cnt;
  logic [DW-1:0] death_cnt;
  logic          hit_pending;
  logic          press;
  logic          hit_ok;

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .WIDTH          (4)
  ) u_debounce (
    .clk    (clk),
    .reset  (reset),
    .btn_raw(btn_raw),
    .press  (press)
  );

  assign hit_ok = hit && active_video && (grace_cnt == '0);

  // Collisions are only latched mid-frame and committed on frame_tick
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_START;
      grace_cnt   <= '0;
      death_cnt   <= '0;
      hit_pending <= 1'b0;
      round_reset <= 1'b0;
      play_frames <= '0;
    end else begin
      round_reset <= 1'b0;
      if (debug) begin
        state       <= ST_START;
        round_reset <= (state != ST_START);
        hit_pending <= 1'b0;
        death_cnt   <= '0;
      end else begin
        case (state)
          ST_START: begin
            grace_cnt   <= GW'(GRACE_FRAMES);
            play_frames <= '0;
            hit_pending <= 1'b0;
            if (press) begin
              state       <= ST_PLAY;
              round_reset <= 1'b1;
            end
          end
          ST_PLAY: begin
            if (frame_tick) begin
              hit_pending <= 1'b0;
              if (hit_pending || hit_ok) begin
                state     <= ST_DYING;
                death_cnt <= DW'(DEATH_FRAMES);
              end else begin
                if (grace_cnt != '0) grace_cnt <= grace_cnt - 1'b1;
                if (play_frames != '1) play_frames <= play_frames + 1'b1;
              end
            end else if (hit_ok) begin
              hit_pending <= 1'b1;
            end
          end
          ST_DYING: begin
            if (frame_tick) begin
              if (death_cnt <= DW'(1)) begin
                state     <= ST_OVER;
                death_cnt <= '0;
              end else begin
                death_cnt <= death_cnt - 1'b1;
              end
            end
          end
          ST_OVER: begin
            if (press) begin
              state       <= ST_START;
              round_reset <= 1'b1;
            end
          end
          default: state <= ST_START;
        endcase
      end
    end
  end

  assign game_state = state;
  assign halt       = is_dead(state);
  assign show_death = is_dead(state);

endmodule

// File: tb/tb_game_flow_ctrl.sv
// tb/tb_game_flow_ctrl.sv - directed self-checking bench for game_flow_ctrl
module tb_game_flow_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  btn_raw = 4'b0;
  logic        debug = 1'b0;
  logic        frame_tick = 1'b0;
  logic        active_video = 1'b0;
  logic        hit = 1'b0;
  logic [1:0]  game_state;
  logic        halt;
  logic        show_death;
  logic        round_reset;
  logic [15:0] play_frames;

  int total = 0;
  int bad = 0;
  int rr_cnt = 0;
  int first_rr = -1;

  game_flow_ctrl #(
    .DEBOUNCE_CYCLES(4),
    .GRACE_FRAMES   (2),
    .DEATH_FRAMES   (3),
    .SCORE_W        (16)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .btn_raw     (btn_raw),
    .debug       (debug),
    .frame_tick  (frame_tick),
    .active_video(active_video),
    .hit         (hit),
    .game_state  (game_state),
    .halt        (halt),
    .show_death  (show_death),
    .round_reset (round_reset),
    .play_frames (play_frames)
  );

  always #5 clk = ~clk;

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      if (round_reset === 1'b1) rr_cnt++;
    end
  endtask

  task automatic tick();
    frame_tick = 1'b1;
    step(1);
    frame_tick = 1'b0;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    // 1. reset
    step(3);
    reset = 1'b0;
    step(1);
    chk("reset_state", 32'(game_state), 32'd0);
    chk("reset_halt", 32'(halt), 32'd0);
    chk("reset_death", 32'(show_death), 32'd0);
    chk("reset_rr", 32'(round_reset), 32'd0);
    chk("reset_frames", 32'(play_frames), 32'd0);

    // 2. glitch then real press
    rr_cnt = 0;
    btn_raw = 4'b0100;
    step(3);
    btn_raw = 4'b0000;
    step(10);
    chk("glitch_state", 32'(game_state), 32'd0);
    chk("glitch_rr", 32'(rr_cnt), 32'd0);

    btn_raw = 4'b0100;
    for (int k = 1; k <= 20; k++) begin
      step(1);
      if (round_reset === 1'b1 && first_rr < 0) first_rr = k;
    end
    chk("press_rr_count", 32'(rr_cnt), 32'd1);
    chk("press_rr_cycle", 32'(first_rr), 32'd7);
    chk("press_state", 32'(game_state), 32'd1);
    chk("press_halt", 32'(halt), 32'd0);

    // 3. grace then committed hit
    tick();
    chk("grace_frames1", 32'(play_frames), 32'd1);
    hit = 1'b1; active_video = 1'b1;
    step(1);
    hit = 1'b0;
    tick();
    chk("grace_state", 32'(game_state), 32'd1);
    chk("grace_frames2", 32'(play_frames), 32'd2);
    hit = 1'b1;
    step(1);
    hit = 1'b0;
    step(2);
    chk("hit_midframe_state", 32'(game_state), 32'd1);
    tick();
    chk("hit_dying_state", 32'(game_state), 32'd3);
    chk("hit_show_death", 32'(show_death), 32'd1);
    chk("hit_halt", 32'(halt), 32'd1);

    // 4. DYING -> OVER, held button does not restart
    tick();
    tick();
    chk("dying_after2", 32'(game_state), 32'd3);
    tick();
    chk("over_state", 32'(game_state), 32'd2);
    chk("over_frames", 32'(play_frames), 32'd2);
    step(20);
    chk("over_held_btn", 32'(game_state), 32'd2);
    btn_raw = 4'b0000;
    step(10);
    chk("over_release", 32'(game_state), 32'd2);
    rr_cnt = 0;
    btn_raw = 4'b0001;
    step(10);
    chk("over_repress_state", 32'(game_state), 32'd0);
    chk("over_repress_rr", 32'(rr_cnt), 32'd1);
    chk("start_frames_clr", 32'(play_frames), 32'd0);
    btn_raw = 4'b0000;
    step(10);

    // 5. debug
    btn_raw = 4'b1000;
    step(10);
    btn_raw = 4'b0000;
    step(10);
    chk("play_again", 32'(game_state), 32'd1);
    rr_cnt = 0;
    debug = 1'b1;
    step(1);
    debug = 1'b0;
    chk("debug_state", 32'(game_state), 32'd0);
    chk("debug_rr", 32'(round_reset), 32'd1);
    step(1);
    chk("debug_rr_once", 32'(round_reset), 32'd0);
    debug = 1'b1;
    step(1);
    debug = 1'b0;
    chk("debug_start_rr", 32'(round_reset), 32'd0);
    step(1);
    chk("debug_rr_total", 32'(rr_cnt), 32'd1);

    // 6. blanking hit ignored, same-tick hit, reset mid-DYING
    btn_raw = 4'b0010;
    step(10);
    btn_raw = 4'b0000;
    step(10);
    tick();
    tick();
    hit = 1'b1; active_video = 1'b0;
    step(5);
    tick();
    hit = 1'b0;
    chk("blank_hit_state", 32'(game_state), 32'd1);
    chk("blank_hit_frames", 32'(play_frames), 32'd3);
    hit = 1'b1; active_video = 1'b1; frame_tick = 1'b1;
    step(1);
    hit = 1'b0; frame_tick = 1'b0;
    chk("sametick_dying", 32'(game_state), 32'd3);
    tick();
    rr_cnt = 0;
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    chk("midreset_state", 32'(game_state), 32'd0);
    chk("midreset_halt", 32'(halt), 32'd0);
    chk("midreset_frames", 32'(play_frames), 32'd0);
    chk("midreset_rr", 32'(rr_cnt), 32'd0);

    // death counter reloads fully after the reset
    btn_raw = 4'b0100;
    step(10);
    btn_raw = 4'b0000;
    step(10);
    tick();
    tick();
    hit = 1'b1; frame_tick = 1'b1;
    step(1);
    hit = 1'b0; frame_tick = 1'b0;
    tick();
    tick();
    chk("reload_dying", 32'(game_state), 32'd3);
    tick();
    chk("reload_over", 32'(game_state), 32'd2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
